// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Data-memory request/response bus between the access unit and RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] mem_address;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_byte_enable;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : LC-3b data-memory stage: EA formation, LDB/LDW/STB/STW/LDI/STI.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             is_store,
    input  wire logic             byteword,
    input  wire logic             zextsext,
    input  wire logic             indirect,
    input  wire logic [WIDTH-1:0] base,
    input  wire logic [WIDTH-1:0] offset,
    input  wire logic [WIDTH-1:0] store_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fault,
    output logic [WIDTH-1:0]      load_data,
    mem_access_unit_if.master     mem
);
    localparam int       c_cnt_w    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam bit       c_to_en    = (MAX_WAIT > 0);
    localparam int       c_cnt_last = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;
    localparam bit [1:0] c_f_ok     = 2'b00;
    localparam bit [1:0] c_f_align  = 2'b01;
    localparam bit [1:0] c_f_tmo    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IND_RD = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_ea;
    logic               r_is_store;
    logic               r_byteword;
    logic               r_zextsext;
    logic [WIDTH-1:0]   r_store_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_fault;
    logic [WIDTH-1:0]   r_load_data;
    logic [WIDTH-1:0]   r_mem_address;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [1:0]         r_mem_be;
    logic [WIDTH-1:0]   r_mem_wdata;

    logic [WIDTH-1:0]   w_ea;
    logic               w_req;
    logic               w_timeout;
    logic [7:0]         w_rbyte;
    logic [WIDTH-1:0]   w_load_val;

    function automatic logic [1:0] f_be(input logic bw, input logic a0);
        return bw ? 2'b11 : (a0 ? 2'b10 : 2'b01);
    endfunction

    // Byte stores replicate the low byte onto both lanes; the enables pick one.
    function automatic logic [WIDTH-1:0] f_wdata(input logic bw, input logic [WIDTH-1:0] sd);
        return bw ? sd : WIDTH'({2{sd[7:0]}});
    endfunction

    assign w_ea       = base + offset;
    assign w_req      = r_mem_read | r_mem_write;
    assign w_timeout  = c_to_en && (r_cnt == c_cnt_w'(c_cnt_last));
    assign w_rbyte    = r_ea[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
    assign w_load_val = r_byteword ? mem.mem_rdata
                                   : {{(WIDTH-8){r_zextsext & w_rbyte[7]}}, w_rbyte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ea          <= '0;
            r_is_store    <= 1'b0;
            r_byteword    <= 1'b0;
            r_zextsext    <= 1'b0;
            r_store_data  <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= c_f_ok;
            r_load_data   <= '0;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_be      <= 2'b00;
            r_mem_wdata   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ea         <= w_ea;
                        r_is_store   <= is_store;
                        r_byteword   <= byteword;
                        r_zextsext   <= zextsext;
                        r_store_data <= store_data;
                        r_cnt        <= '0;
                        // The pointer fetch of LDI/STI is always a word read.
                        if (indirect ? w_ea[0] : (byteword & w_ea[0])) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_fault <= c_f_align;
                        end else if (indirect) begin
                            r_state       <= S_IND_RD;
                            r_busy        <= 1'b1;
                            r_mem_read    <= 1'b1;
                            r_mem_be      <= 2'b11;
                            r_mem_address <= w_ea;
                        end else begin
                            r_state       <= S_ACCESS;
                            r_busy        <= 1'b1;
                            r_mem_read    <= ~is_store;
                            r_mem_write   <= is_store;
                            r_mem_be      <= f_be(byteword, w_ea[0]);
                            r_mem_address <= w_ea;
                            r_mem_wdata   <= f_wdata(byteword, store_data);
                        end
                    end
                end
                S_IND_RD: begin
                    if (mem.mem_resp) begin
                        r_mem_read <= 1'b0;
                        r_mem_be   <= 2'b00;
                        r_ea       <= mem.mem_rdata;
                        r_cnt      <= '0;
                        if (r_byteword & mem.mem_rdata[0]) begin
                            r_state <= S_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_fault <= c_f_align;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end else if (w_timeout) begin
                        r_mem_read <= 1'b0;
                        r_mem_be   <= 2'b00;
                        r_state    <= S_FINISH;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_fault    <= c_f_tmo;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACCESS: begin
                    // No request outstanding here means we arrived from the pointer fetch.
                    if (!w_req) begin
                        r_mem_read    <= ~r_is_store;
                        r_mem_write   <= r_is_store;
                        r_mem_be      <= f_be(r_byteword, r_ea[0]);
                        r_mem_address <= r_ea;
                        r_mem_wdata   <= f_wdata(r_byteword, r_store_data);
                        r_cnt         <= '0;
                    end else if (mem.mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_be    <= 2'b00;
                        r_state     <= S_FINISH;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= c_f_ok;
                        if (!r_is_store) begin
                            r_load_data <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_be    <= 2'b00;
                        r_state     <= S_FINISH;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= c_f_tmo;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign fault               = r_fault;
    assign load_data           = r_load_data;
    assign mem.mem_address     = r_mem_address;
    assign mem.mem_read        = r_mem_read;
    assign mem.mem_write       = r_mem_write;
    assign mem.mem_byte_enable = r_mem_be;
    assign mem.mem_wdata       = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_store = 1'b0, byteword = 1'b0, zextsext = 1'b0, indirect = 1'b0;
    logic [15:0] base = '0, offset = '0, store_data = '0;
    logic        busy, done;
    logic [1:0]  fault;
    logic [15:0] load_data;

    mem_access_unit_if #(.WIDTH(16)) bus ();

    mem_access_unit #(.WIDTH(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .byteword(byteword), .zextsext(zextsext), .indirect(indirect),
        .base(base), .offset(offset), .store_data(store_data),
        .busy(busy), .done(done), .fault(fault), .load_data(load_data),
        .mem(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_ld = '0;

    // Observations of one transaction
    int          o_nreq, o_hi, o_cyc_done, o_cyc_resp, o_cyc_req0, o_unstable, o_busy_bad;
    logic        o_done;
    logic [1:0]  o_fault;
    logic [15:0] o_addr [2];
    logic        o_rd   [2];
    logic        o_wr   [2];
    logic [1:0]  o_be   [2];
    logic [15:0] o_wd   [2];

    typedef struct {
        int          nreq;
        logic [15:0] a0, a1;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [1:0]  fault;
        logic [15:0] ld;
    } exp_t;

    // Architectural model: what an LC-3b load/store must do, independent of timing.
    function automatic exp_t model(input logic st, bw, zs, ind,
                                   input logic [15:0] b, o, sd, d0, d1);
        exp_t m;
        logic [15:0] ea, data;
        int byt;
        m.nreq = 0; m.a0 = 0; m.a1 = 0; m.be = 0; m.wd = 0; m.fault = 0; m.ld = 0;
        ea = 16'((int'(b) + int'(o)) % 65536);
        data = d0;
        if (ind) begin
            if (ea % 2 == 1) begin m.fault = 2'b01; return m; end
            m.a0 = ea; m.nreq = 1; ea = d0; data = d1;
        end
        if (bw && (ea % 2 == 1)) begin m.fault = 2'b01; return m; end
        if (ind) m.a1 = ea; else m.a0 = ea;
        m.nreq = m.nreq + 1;
        m.be = bw ? 2'b11 : ((ea % 2 == 1) ? 2'b10 : 2'b01);
        m.wd = bw ? sd : 16'((int'(sd) % 256) * 257);
        if (bw) m.ld = data;
        else begin
            byt = (ea % 2 == 1) ? int'(data) / 256 : int'(data) % 256;
            m.ld = (zs && byt >= 128) ? 16'(byt + 65280) : 16'(byt);
        end
        return m;
    endfunction

    // Issues one request and plays the memory; dly < 0 means memory never answers.
    task automatic run_op(input logic st, bw, zs, ind,
                          input logic [15:0] b, o, sd, d0, d1, input int dly);
        logic prev, req;
        int age;
        @(negedge clk);
        start = 1'b1; is_store = st; byteword = bw; zextsext = zs; indirect = ind;
        base = b; offset = o; store_data = sd;
        o_nreq = 0; o_hi = 0; o_cyc_done = 0; o_cyc_resp = 0; o_cyc_req0 = 0;
        o_unstable = 0; o_busy_bad = 0; o_done = 1'b0; o_fault = 2'b11;
        prev = 1'b0; age = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus.mem_resp = 1'b0;
            bus.mem_rdata = 16'($urandom);
            if (done) begin
                o_done = 1'b1; o_fault = fault; o_cyc_done = c;
                if (busy) o_busy_bad = 1;
                break;
            end
            req = bus.mem_read | bus.mem_write;
            if (req) begin
                o_hi++;
                if (!prev) begin
                    if (o_nreq == 0) o_cyc_req0 = c;
                    if (o_nreq < 2) begin
                        o_addr[o_nreq] = bus.mem_address; o_rd[o_nreq] = bus.mem_read;
                        o_wr[o_nreq] = bus.mem_write; o_be[o_nreq] = bus.mem_byte_enable;
                        o_wd[o_nreq] = bus.mem_wdata;
                    end
                    o_nreq++;
                    age = 0;
                end else if (o_nreq <= 2 && (bus.mem_address !== o_addr[o_nreq-1] ||
                             bus.mem_byte_enable !== o_be[o_nreq-1] ||
                             bus.mem_wdata !== o_wd[o_nreq-1])) begin
                    o_unstable++;
                end
                if (dly >= 0 && age == dly) begin
                    bus.mem_resp = 1'b1;
                    bus.mem_rdata = (o_nreq == 1) ? d0 : d1;
                    o_cyc_resp = c;
                end
                age++;
            end
            prev = req;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, done, fault} !== 4'b0) $display("FAIL reset_status got %b exp 0000", {busy, done, fault}); else n_pass++;
        n_checks++; if (load_data !== 16'h0) $display("FAIL reset_load_data got %h exp 0000", load_data); else n_pass++;
        n_checks++; if ({bus.mem_read, bus.mem_write, bus.mem_byte_enable} !== 4'b0) $display("FAIL reset_req got %b exp 0000", {bus.mem_read, bus.mem_write, bus.mem_byte_enable}); else n_pass++;
        n_checks++; if ({bus.mem_address, bus.mem_wdata} !== 32'h0) $display("FAIL reset_addr_wdata got %h exp 0", {bus.mem_address, bus.mem_wdata}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1234;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        n_checks++; if ({busy, done, load_data} !== 18'h0) $display("FAIL stray_resp got busy=%b done=%b ld=%h exp all 0", busy, done, load_data); else n_pass++;
        exp_ld = 16'h0;
    endtask

    task automatic test_ldb_sext();
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0001, 16'h0, 16'h8012, 16'h0, 2);
        exp_ld = 16'hFF80;
        n_checks++; if (o_addr[0] !== 16'h3001) $display("FAIL ldb_addr got %h exp 3001", o_addr[0]); else n_pass++;
        n_checks++; if (o_be[0] !== 2'b10) $display("FAIL ldb_be got %b exp 10", o_be[0]); else n_pass++;
        n_checks++; if (load_data !== 16'hFF80) $display("FAIL ldb_data got %h exp FF80", load_data); else n_pass++;
        n_checks++; if (o_cyc_req0 !== 1) $display("FAIL ldb_req_latency got %0d exp 1", o_cyc_req0); else n_pass++;
        n_checks++; if (!o_done || o_cyc_done !== o_cyc_resp + 1) $display("FAIL ldb_done_latency got %0d exp %0d", o_cyc_done, o_cyc_resp + 1); else n_pass++;
        n_checks++; if (o_fault !== 2'b00 || o_busy_bad != 0) $display("FAIL ldb_fault got %b busy_bad=%0d exp 00", o_fault, o_busy_bad); else n_pass++;
    endtask

    task automatic test_stb();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h12AB, 16'h0, 16'h0, 1);
        n_checks++; if (o_wr[0] !== 1'b1 || o_rd[0] !== 1'b0) $display("FAIL stb_kind got rd=%b wr=%b exp rd=0 wr=1", o_rd[0], o_wr[0]); else n_pass++;
        n_checks++; if ({o_be[0], o_wd[0], o_addr[0]} !== {2'b01, 16'hABAB, 16'h4000}) $display("FAIL stb_bus got be=%b wd=%h a=%h exp be=01 wd=ABAB a=4000", o_be[0], o_wd[0], o_addr[0]); else n_pass++;
        n_checks++; if (!o_done || o_cyc_done !== o_cyc_resp + 1) $display("FAIL stb_done got %0d exp %0d", o_cyc_done, o_cyc_resp + 1); else n_pass++;
        n_checks++; if (load_data !== exp_ld) $display("FAIL stb_ld_hold got %h exp %h", load_data, exp_ld); else n_pass++;
    endtask

    task automatic test_misaligned();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h1001, 16'h0000, 16'h0, 16'hAAAA, 16'h0, 0);
        n_checks++; if (o_nreq !== 0) $display("FAIL misalign_noreq got %0d requests exp 0", o_nreq); else n_pass++;
        n_checks++; if (!o_done || o_cyc_done > 2 || o_fault !== 2'b01) $display("FAIL misalign_done got done=%b cyc=%0d fault=%b exp fault=01 cyc<=2", o_done, o_cyc_done, o_fault); else n_pass++;
        n_checks++; if (load_data !== exp_ld) $display("FAIL misalign_ld got %h exp %h", load_data, exp_ld); else n_pass++;
    endtask

    task automatic test_indirect();
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0010, 16'h0, 16'h5000, 16'hBEEF, 1);
        exp_ld = 16'hBEEF;
        n_checks++; if (o_nreq !== 2 || o_addr[0] !== 16'h2010 || o_addr[1] !== 16'h5000) $display("FAIL ldi_addrs got n=%0d %h %h exp 2 2010 5000", o_nreq, o_addr[0], o_addr[1]); else n_pass++;
        n_checks++; if (o_be[0] !== 2'b11 || o_rd[1] !== 1'b1) $display("FAIL ldi_req got be0=%b rd1=%b exp 11 1", o_be[0], o_rd[1]); else n_pass++;
        n_checks++; if (load_data !== 16'hBEEF || o_fault !== 2'b00) $display("FAIL ldi_data got %h f=%b exp BEEF 00", load_data, o_fault); else n_pass++;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0010, 16'h0, 16'h5001, 16'h7777, 0);
        n_checks++; if (o_nreq !== 1 || o_fault !== 2'b01 || !o_done) $display("FAIL ldi_badptr got n=%0d f=%b exp 1 01", o_nreq, o_fault); else n_pass++;
        n_checks++; if (load_data !== exp_ld) $display("FAIL ldi_badptr_ld got %h exp %h", load_data, exp_ld); else n_pass++;
    endtask

    task automatic test_timeout();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0600, 16'h0002, 16'h0, 16'h0, 16'h0, -1);
        n_checks++; if (o_hi !== 4) $display("FAIL timeout_cycles got %0d exp 4", o_hi); else n_pass++;
        n_checks++; if (!o_done || o_fault !== 2'b10) $display("FAIL timeout_fault got done=%b f=%b exp 10", o_done, o_fault); else n_pass++;
        n_checks++; if (load_data !== exp_ld) $display("FAIL timeout_ld got %h exp %h", load_data, exp_ld); else n_pass++;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0700, 16'h0000, 16'h0, 16'h4321, 16'h0, 3);
        exp_ld = 16'h4321;
        n_checks++; if (o_fault !== 2'b00 || load_data !== 16'h4321) $display("FAIL timeout_resp_priority got f=%b ld=%h exp 00 4321", o_fault, load_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; byteword = 1'b1; indirect = 1'b0; base = 16'h0100; offset = 16'h0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_read !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_drop got rd=%b busy=%b exp 0 0", bus.mem_read, busy); else n_pass++;
        @(negedge clk); if (done) dn++;
        rst_n = 1'b1;
        @(negedge clk); if (done) dn++;
        @(negedge clk); if (done) dn++;
        n_checks++; if (dn !== 0) $display("FAIL rst_mid_nodone got %0d done pulses exp 0", dn); else n_pass++;
        exp_ld = 16'h0;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0, 16'h9ABC, 16'h0, 0);
        exp_ld = 16'h9ABC;
        n_checks++; if (o_fault !== 2'b00 || load_data !== 16'h9ABC || o_addr[0] !== 16'h0100) $display("FAIL rst_mid_after got f=%b ld=%h a=%h exp 00 9ABC 0100", o_fault, load_data, o_addr[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ndone = 0, nreq = 0, last_done = 0, bad_gap = 0, bad_ld = 0, age = 0;
        logic prev = 1'b0, req;
        logic [15:0] last_data = '0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; byteword = 1'b1; indirect = 1'b0; base = 16'h0200; offset = 16'h0004;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            if (c >= 32) start = 1'b0;
            bus.mem_resp = 1'b0;
            if (done) begin
                ndone++;
                if (last_done > 0 && c - last_done != 4) bad_gap++;
                if (load_data !== last_data) bad_ld++;
                last_done = c;
            end
            req = bus.mem_read | bus.mem_write;
            if (req) begin
                if (!prev) begin nreq++; age = 0; end
                if (age == 1) begin
                    bus.mem_resp = 1'b1; bus.mem_rdata = 16'($urandom); last_data = bus.mem_rdata;
                end
                age++;
            end
            prev = req;
        end
        exp_ld = last_data;
        n_checks++; if (ndone !== nreq || ndone < 7) $display("FAIL b2b_count got done=%0d req=%0d exp equal and >=7", ndone, nreq); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL b2b_spacing got %0d bad gaps exp 0", bad_gap); else n_pass++;
        n_checks++; if (bad_ld !== 0) $display("FAIL b2b_load got %0d bad loads exp 0", bad_ld); else n_pass++;
    endtask

    task automatic test_wrap();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0004, 16'h0, 16'h0F0F, 16'h0, 1);
        exp_ld = 16'h0F0F;
        n_checks++; if (o_addr[0] !== 16'h0002 || load_data !== 16'h0F0F) $display("FAIL wrap got a=%h ld=%h exp 0002 0F0F", o_addr[0], load_data); else n_pass++;
    endtask

    task automatic test_random();
        exp_t m;
        logic st, bw, zs, ind;
        logic [15:0] b, o, sd, d0, d1;
        int k;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom); bw = 1'($urandom); zs = 1'($urandom); ind = ($urandom_range(0, 3) == 0);
            b = 16'($urandom); o = 16'($urandom); sd = 16'($urandom); d0 = 16'($urandom); d1 = 16'($urandom);
            if ($urandom_range(0, 3) != 0) b[0] = o[0];
            if ($urandom_range(0, 3) != 0) d0[0] = 1'b0;
            m = model(st, bw, zs, ind, b, o, sd, d0, d1);
            run_op(st, bw, zs, ind, b, o, sd, d0, d1, $urandom_range(0, 3));
            if (m.fault == 2'b00 && !st) exp_ld = m.ld;
            n_checks++; if (!o_done || o_fault !== m.fault || o_nreq !== m.nreq) $display("FAIL rnd%0d_status got done=%b f=%b n=%0d exp f=%b n=%0d", i, o_done, o_fault, o_nreq, m.fault, m.nreq); else n_pass++;
            n_checks++; if (load_data !== exp_ld) $display("FAIL rnd%0d_load got %h exp %h", i, load_data, exp_ld); else n_pass++;
            n_checks++; if (o_unstable !== 0 || o_busy_bad !== 0) $display("FAIL rnd%0d_stable got unstable=%0d busy_bad=%0d exp 0 0", i, o_unstable, o_busy_bad); else n_pass++;
            if (m.fault == 2'b00 && o_nreq == m.nreq) begin
                k = m.nreq - 1;
                n_checks++; if (o_addr[k] !== (ind ? m.a1 : m.a0) || o_be[k] !== m.be) $display("FAIL rnd%0d_addr got a=%h be=%b exp a=%h be=%b", i, o_addr[k], o_be[k], ind ? m.a1 : m.a0, m.be); else n_pass++;
                n_checks++; if (o_rd[k] !== !st || o_wr[k] !== st || (st && o_wd[k] !== m.wd)) $display("FAIL rnd%0d_kind got rd=%b wr=%b wd=%h exp wd=%h", i, o_rd[k], o_wr[k], o_wd[k], m.wd); else n_pass++;
                if (ind) begin
                    n_checks++; if (o_addr[0] !== m.a0 || o_be[0] !== 2'b11 || o_rd[0] !== 1'b1) $display("FAIL rnd%0d_ptr got a=%h be=%b exp a=%h be=11", i, o_addr[0], o_be[0], m.a0); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldb_sext();
        test_stb();
        test_misaligned();
        test_indirect();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the offset extension unit.
- Takes a base register value plus the already-extended 16-bit offset, forms the effective address, and runs the memory handshake for LDB/LDW/STB/STW and the indirect variants LDI/STI.
- Byte/word lane alignment is handled here, and load results are returned zero- or sign-extended to the register file writeback mux.

Parameters:
WIDTH, 16, datapath and address width (lc3b_word).
MAX_WAIT, 0, max cycles waiting on mem_resp per access; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
is_store  input  1  0 = load, 1 = store
byteword  input  1  0 = byte access, 1 = word access
zextsext  input  1  byte-load extension: 0 = zero-extend, 1 = sign-extend
indirect  input  1  1 = LDI/STI, one extra word read to fetch the final address
base  input  WIDTH  base register value
offset  input  WIDTH  extended offset from the extension unit
store_data  input  WIDTH  store source register value
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
fault  output  2  valid with done: 00 ok, 01 misaligned word, 10 timeout
load_data  output  WIDTH  registered load result; holds until the next load completes OK
mem_address  output  WIDTH  memory address
mem_read  output  1  read request
mem_write  output  1  write request
mem_byte_enable  output  2  lane enables [1] = high byte, [0] = low byte
mem_wdata  output  WIDTH  write data
mem_rdata  input  WIDTH  read data, valid with mem_resp
mem_resp  input  1  memory response; completes the outstanding request

Behaviour:
- Reset (async, rst_n = 0): state IDLE; busy = 0, done = 0, fault = 00, load_data = 0, mem_read = 0, mem_write = 0, mem_byte_enable = 00, mem_address = 0, mem_wdata = 0, wait counter = 0.
- Reset mid-operation: requests drop immediately and the access is abandoned with no done pulse.
- States: IDLE, IND_RD, ACCESS, FINISH. All outputs are registered.
- IDLE + start:
  - Latch ea = (base + offset) mod 2^16 and latch all control inputs.
  - If indirect = 1 -> IND_RD.
  - Else if byteword = 1 and ea[0] = 1 -> FINISH with fault 01; no memory request is issued.
  - Else -> ACCESS.
  - start asserted while not in IDLE is ignored.
- Indirect pointer check: the pointer read in IND_RD is a word read. If ea[0] = 1 on entry, take the fault 01 path instead.
- IND_RD:
  - mem_read = 1, mem_byte_enable = 11, mem_address = ea.
  - On mem_resp: ea := mem_rdata. The pointer-read request drops for one cycle before the ACCESS request is raised.
  - The alignment check on the new ea is then applied, as in IDLE.
- ACCESS:
  - Request outputs are held stable until mem_resp.
  - Word access: mem_byte_enable = 11, mem_wdata = store_data.
  - Byte access: mem_byte_enable = 10 if ea[0] = 1, else 01; mem_wdata = {store_data[7:0], store_data[7:0]}.
  - mem_address = ea in both cases; no bit is cleared.
  - On mem_resp -> FINISH.
    - Load, word: load_data = mem_rdata.
    - Load, byte: select mem_rdata[15:8] if ea[0] = 1, else mem_rdata[7:0]; then zero- or sign-extend per zextsext.
- FINISH: done = 1 for exactly one cycle with fault valid, busy = 0 in that cycle, return to IDLE. A new start is accepted the following cycle.
- Request timing: mem_read/mem_write go high the cycle after the transition into IND_RD/ACCESS and drop in the cycle after mem_resp is sampled.
- mem_resp while no request is outstanding is ignored.
- Latency (no indirection, aligned): start at cycle N, request high from N+1, mem_resp at cycle M (M >= N+1), done at M+1.
- Timeout (MAX_WAIT > 0):
  - The counter increments each cycle a request is high without mem_resp and resets on entry to each request state.
  - When the count reaches MAX_WAIT the request drops -> FINISH with fault 10; load_data is unchanged.
  - mem_resp in the same cycle as the timeout takes priority, and the access completes normally.
- Address arithmetic wraps: base = FFFE, offset = 0004 gives ea = 0002.
- On any fault, load_data is not updated.

Test Plan:
- Byte sign-extend load: LDB, base = 3000, offset = 0001, zextsext = 1, mem_rdata = 8012, resp 2 cycles after request -> mem_address = 3001, byte_enable = 10, load_data = FF80, done 1 cycle after resp, fault 00.
- Byte store: STB, base = 4000, offset = 0000, store_data = 12AB -> mem_write with byte_enable = 01, mem_wdata = ABAB, address 4000; done one cycle after resp.
- Misaligned word: LDW, base = 1001, offset = 0000 -> no mem_read ever asserted, done with fault 01 within 2 cycles of start, load_data unchanged.
- Indirect: LDI, base = 2000, offset = 0010, first mem_rdata = 5000, second mem_rdata = BEEF -> two reads at 2010 then 5000, load_data = BEEF. Also a pointer of 5001 with a word access -> fault 01.
- Timeout and reset: MAX_WAIT = 4 with no mem_resp -> request drops after 4 cycles, fault 10. Separately, assert rst_n = 0 mid-ACCESS -> mem_read low immediately, no done, and the next start is accepted normally.
- Back-to-back and wrap: start held high continuously -> one access per done, with starts during busy ignored. base = FFFE, offset = 0004 -> address 0002.
